// File: rtl/ptosda_tx_if.sv
// Parallel-request / two-wire serial bundle for ptosda_tx.
// master: the transmitter (requests data, drives scl/sda).
// slave:  the data source / line observer.
interface ptosda_tx_if;
    localparam int unsigned NIBBLE_W = 4;

    logic                enable;
    logic [NIBBLE_W-1:0] data;
    logic                ask_for_data;
    logic                scl;
    logic                sda;
    logic                busy;
    logic                frame_done;

    modport master (
        input  enable,
        input  data,
        output ask_for_data,
        output scl,
        output sda,
        output busy,
        output frame_done
    );

    modport slave (
        output enable,
        output data,
        input  ask_for_data,
        input  scl,
        input  sda,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/ptosda_tx.sv
// ptosda_tx: requests a nibble from the parallel source, latches it one
// cycle later and serialises it on scl/sda as start, 4 data bits, stop.
// Frames repeat while enable is high, separated by GAP_CYCLES idle cycles.
// Optional macro PTOSDA_PARITY_EN appends an even-parity bit after the data.
module ptosda_tx #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic        sclk,
    input  logic        rst,
    ptosda_tx_if.master bus
);
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BIT_W  = 2;
    localparam int unsigned LAST_BIT = NIB_W - 1;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        START,
        BIT_LO,
        BIT_HI,
`ifdef PTOSDA_PARITY_EN
        PAR_LO,
        PAR_HI,
`endif
        STOP_LO,
        STOP_HI,
        STOP_END
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NIB_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_q, bit_d;

    logic scl_q, scl_d;
    logic sda_q, sda_d;
    logic ask_q, ask_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Pick the k-th transmitted bit of the latched nibble in wire order.
    function automatic logic tx_bit(input logic [NIB_W-1:0] nib, input logic [BIT_W-1:0] k);
        logic [BIT_W-1:0] idx;
        if (MSB_FIRST) begin
            idx = BIT_W'(LAST_BIT) - k;
        end else begin
            idx = k;
        end
        return nib[idx];
    endfunction

    // State, counters and registered line outputs.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gap_q   <= GAP_W'(GAP_CYCLES);
            shreg_q <= '0;
            bit_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            ask_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            ask_q   <= ask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, counters, and the output values for the next state.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        scl_d   = 1'b1;
        sda_d   = 1'b1;
        ask_d   = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Counter at 1 means it reaches 0 at this edge: the gap is spent.
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end
                if ((gap_q <= GAP_W'(1)) && bus.enable) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                shreg_d = bus.data;
                state_d = START;
            end
            START: begin
                state_d = BIT_LO;
            end
            BIT_LO: begin
                state_d = BIT_HI;
            end
            BIT_HI: begin
                // 2-bit counter wraps 3 -> 0 when the last data bit is left.
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(LAST_BIT)) begin
`ifdef PTOSDA_PARITY_EN
                    state_d = PAR_LO;
`else
                    state_d = STOP_LO;
`endif
                end else begin
                    state_d = BIT_LO;
                end
            end
`ifdef PTOSDA_PARITY_EN
            PAR_LO: begin
                state_d = PAR_HI;
            end
            PAR_HI: begin
                state_d = STOP_LO;
            end
`endif
            STOP_LO: begin
                state_d = STOP_HI;
            end
            STOP_HI: begin
                state_d = STOP_END;
            end
            STOP_END: begin
                state_d = IDLE;
                gap_d   = GAP_W'(GAP_CYCLES);
            end
            default: begin
                state_d = IDLE;
                gap_d   = GAP_W'(GAP_CYCLES);
            end
        endcase

        unique case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            REQ: begin
                ask_d = 1'b1;
            end
            START: begin
                sda_d = 1'b0;
            end
            BIT_LO: begin
                scl_d = 1'b0;
                sda_d = tx_bit(shreg_d, bit_d);
            end
            BIT_HI: begin
                sda_d = sda_q;
            end
`ifdef PTOSDA_PARITY_EN
            PAR_LO: begin
                scl_d = 1'b0;
                sda_d = ^shreg_q;
            end
            PAR_HI: begin
                sda_d = sda_q;
            end
`endif
            STOP_LO: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
            STOP_HI: begin
                sda_d = 1'b0;
            end
            STOP_END: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.scl          = scl_q;
    assign bus.sda          = sda_q;
    assign bus.ask_for_data = ask_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_ptosda_tx.sv
// Directed bench for ptosda_tx (GAP_CYCLES=4, MSB first).
// Builds with or without PTOSDA_PARITY_EN; the parity build runs the parity frames.
module tb_ptosda_tx;
`ifdef PTOSDA_PARITY_EN
    localparam int unsigned FL = 15;
`else
    localparam int unsigned FL = 13;
`endif

    typedef logic [0:FL-1] vec_t;

    logic sclk;
    logic rst;
    int   vectors;
    int   miscompares;

    vec_t cap_scl, cap_sda, cap_ask, cap_busy, cap_done;

    ptosda_tx_if bus ();

    ptosda_tx #(
        .GAP_CYCLES(4),
        .MSB_FIRST (1'b1)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .bus (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance until ask_for_data is seen (bounded); n = posedges taken.
    task automatic wait_req(output int n, output bit found);
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge sclk);
            #1;
            n++;
            if (bus.ask_for_data === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Capture one frame starting from a sampled REQ cycle; source drives nib
    // half a cycle after the request and scrambles it after the latch edge.
    task automatic run_frame(input logic [3:0] nib, input int drop_at);
        cap_scl[0]  = bus.scl;
        cap_sda[0]  = bus.sda;
        cap_ask[0]  = bus.ask_for_data;
        cap_busy[0] = bus.busy;
        cap_done[0] = bus.frame_done;
        @(negedge sclk);
        bus.data = nib;
        for (int i = 1; i < int'(FL); i++) begin
            @(posedge sclk);
            #1;
            if (i == 1) bus.data = ~nib;
            cap_scl[i]  = bus.scl;
            cap_sda[i]  = bus.sda;
            cap_ask[i]  = bus.ask_for_data;
            cap_busy[i] = bus.busy;
            cap_done[i] = bus.frame_done;
            if (i == drop_at) bus.enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        bit found;
        rst        = 1'b0;
        bus.enable = 1'b1;
        bus.data   = 4'h0;
        repeat (3) @(posedge sclk);
        #1;
        vectors++;
        if (bus.scl !== 1'b1) begin miscompares++; $display("FAIL reset_scl: got %b expected 1", bus.scl); end
        vectors++;
        if (bus.sda !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b expected 1", bus.sda); end
        vectors++;
        if (bus.ask_for_data !== 1'b0) begin miscompares++; $display("FAIL reset_ask: got %b expected 0", bus.ask_for_data); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++;
        if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.frame_done); end
        @(negedge sclk);
        rst = 1'b1;
        wait_req(n, found);
        vectors++;
        if (!found || n != 4) begin
            miscompares++;
            $display("FAIL reset_first_req: got found=%0d after %0d edges expected after 4", found, n);
        end
    endtask

`ifdef PTOSDA_PARITY_EN
    localparam vec_t SCL_P  = 15'b110101010101011;
    localparam vec_t ASK_P  = 15'b100000000000000;
    localparam vec_t BUSY_P = 15'b111111111111111;
    localparam vec_t DONE_P = 15'b000000000000001;

    task automatic test_parity();
        logic [3:0] nibs [2];
        vec_t       sda_exp [2];
        int n;
        bit found;
        nibs[0] = 4'b0111; sda_exp[0] = 15'b100011111111001;
        nibs[1] = 4'b0110; sda_exp[1] = 15'b100011110000001;
        for (int f = 0; f < 2; f++) begin
            if (f != 0) begin
                wait_req(n, found);
                vectors++;
                if (!found || n != 5) begin
                    miscompares++;
                    $display("FAIL parity_gap%0d: got found=%0d n=%0d expected n=5", f, found, n);
                end
            end
            run_frame(nibs[f], -1);
            vectors++;
            if (cap_sda !== sda_exp[f]) begin miscompares++; $display("FAIL parity_sda%0d: got %b expected %b", f, cap_sda, sda_exp[f]); end
            vectors++;
            if (cap_scl !== SCL_P) begin miscompares++; $display("FAIL parity_scl%0d: got %b expected %b", f, cap_scl, SCL_P); end
            vectors++;
            if (cap_ask !== ASK_P) begin miscompares++; $display("FAIL parity_ask%0d: got %b expected %b", f, cap_ask, ASK_P); end
            vectors++;
            if (cap_busy !== BUSY_P) begin miscompares++; $display("FAIL parity_busy%0d: got %b expected %b", f, cap_busy, BUSY_P); end
            vectors++;
            if (cap_done !== DONE_P) begin miscompares++; $display("FAIL parity_done%0d: got %b expected %b", f, cap_done, DONE_P); end
        end
    endtask
`else
    localparam vec_t SCL_E  = 13'b1101010101011;
    localparam vec_t ASK_E  = 13'b1000000000000;
    localparam vec_t BUSY_E = 13'b1111111111111;
    localparam vec_t DONE_E = 13'b0000000000001;

    task automatic test_single();
        vec_t sda_exp;
        sda_exp = 13'b1011001100001;
        run_frame(4'b1010, -1);
        vectors++;
        if (cap_sda !== sda_exp) begin miscompares++; $display("FAIL single_sda: got %b expected %b", cap_sda, sda_exp); end
        vectors++;
        if (cap_scl !== SCL_E) begin miscompares++; $display("FAIL single_scl: got %b expected %b", cap_scl, SCL_E); end
        vectors++;
        if (cap_ask !== ASK_E) begin miscompares++; $display("FAIL single_ask: got %b expected %b", cap_ask, ASK_E); end
        vectors++;
        if (cap_busy !== BUSY_E) begin miscompares++; $display("FAIL single_busy: got %b expected %b", cap_busy, BUSY_E); end
        vectors++;
        if (cap_done !== DONE_E) begin miscompares++; $display("FAIL single_done: got %b expected %b", cap_done, DONE_E); end
    endtask

    task automatic test_continuous();
        logic [3:0] nibs [3];
        vec_t       sda_exp [3];
        int n;
        int viol;
        bit found;
        nibs[0] = 4'h0; sda_exp[0] = 13'b1000000000001;
        nibs[1] = 4'hF; sda_exp[1] = 13'b1011111111001;
        nibs[2] = 4'h5; sda_exp[2] = 13'b1000110011001;
        for (int f = 0; f < 3; f++) begin
            wait_req(n, found);
            vectors++;
            if (!found || (12 + n) != 17) begin
                miscompares++;
                $display("FAIL cont_period%0d: got found=%0d period=%0d expected 17", f, found, 12 + n);
            end
            run_frame(nibs[f], -1);
            vectors++;
            if (cap_sda !== sda_exp[f]) begin miscompares++; $display("FAIL cont_sda%0d: got %b expected %b", f, cap_sda, sda_exp[f]); end
            vectors++;
            if (cap_scl !== SCL_E) begin miscompares++; $display("FAIL cont_scl%0d: got %b expected %b", f, cap_scl, SCL_E); end
            vectors++;
            if (cap_done !== DONE_E) begin miscompares++; $display("FAIL cont_done%0d: got %b expected %b", f, cap_done, DONE_E); end
            viol = 0;
            for (int i = 2; i < int'(FL) - 1; i++) begin
                if (cap_scl[i-1] && cap_scl[i] && (cap_sda[i-1] !== cap_sda[i])) viol++;
            end
            vectors++;
            if (viol != 0) begin miscompares++; $display("FAIL cont_sda_while_scl_high%0d: got %0d changes expected 0", f, viol); end
        end
    endtask

    task automatic test_enable_drop();
        vec_t sda_exp;
        int n;
        int asks;
        bit found;
        sda_exp = 13'b1011000011001;
        wait_req(n, found);
        vectors++;
        if (!found || n != 5) begin miscompares++; $display("FAIL drop_req: got found=%0d n=%0d expected n=5", found, n); end
        run_frame(4'h9, 5);
        vectors++;
        if (cap_sda !== sda_exp) begin miscompares++; $display("FAIL drop_sda: got %b expected %b", cap_sda, sda_exp); end
        vectors++;
        if (cap_done !== DONE_E) begin miscompares++; $display("FAIL drop_done: got %b expected %b", cap_done, DONE_E); end
        asks = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge sclk);
            #1;
            if (bus.ask_for_data !== 1'b0) asks++;
        end
        vectors++;
        if (asks != 0) begin miscompares++; $display("FAIL drop_no_req: got %0d requests expected 0", asks); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL drop_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_frame();
        vec_t sda_exp;
        int n;
        bit found;
        sda_exp = 13'b1000001111001;
        bus.enable = 1'b1;
        wait_req(n, found);
        vectors++;
        if (!found || n != 1) begin miscompares++; $display("FAIL midrst_req: got found=%0d n=%0d expected n=1", found, n); end
        @(negedge sclk);
        bus.data = 4'h5;
        for (int i = 1; i <= 6; i++) begin
            @(posedge sclk);
            #1;
        end
        vectors++;
        if (bus.scl !== 1'b0) begin miscompares++; $display("FAIL midrst_pre_scl: got %b expected 0", bus.scl); end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.scl !== 1'b1) begin miscompares++; $display("FAIL midrst_scl: got %b expected 1", bus.scl); end
        vectors++;
        if (bus.sda !== 1'b1) begin miscompares++; $display("FAIL midrst_sda: got %b expected 1", bus.sda); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        rst = 1'b1;
        wait_req(n, found);
        vectors++;
        if (!found || n != 4) begin miscompares++; $display("FAIL midrst_restart: got found=%0d n=%0d expected n=4", found, n); end
        run_frame(4'h3, -1);
        vectors++;
        if (cap_sda !== sda_exp) begin miscompares++; $display("FAIL midrst_sda_frame: got %b expected %b", cap_sda, sda_exp); end
        vectors++;
        if (cap_scl !== SCL_E) begin miscompares++; $display("FAIL midrst_scl_frame: got %b expected %b", cap_scl, SCL_E); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
`ifdef PTOSDA_PARITY_EN
        test_parity();
`else
        test_single();
        test_continuous();
        test_enable_drop();
        test_reset_mid_frame();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
